// File: rtl/stack_machine_pkg.sv
// Shared definitions for the stack machine: memory geometry, opcodes, loader states and error codes.
package stack_machine_pkg;

    localparam int DEPTH  = 32;
    localparam int ADDR_W = 5;
    localparam int INST_W = 12;

    localparam logic [7:0] HEADER = 8'hA5;

    localparam logic [3:0] OP_PUSHC   = 4'd0;
    localparam logic [3:0] OP_PUSHMEM = 4'd1;
    localparam logic [3:0] OP_POP     = 4'd2;
    localparam logic [3:0] OP_J       = 4'd3;
    localparam logic [3:0] OP_JZ      = 4'd4;
    localparam logic [3:0] OP_JS      = 4'd5;
    localparam logic [3:0] OP_ADD     = 4'd6;
    localparam logic [3:0] OP_SUB     = 4'd7;

    typedef enum logic [2:0] {
        IDLE,
        COUNT,
        HI,
        LO,
        CSUM,
        DONE,
        ERR
    } loader_state_t;

    localparam logic [2:0] ERR_NONE    = 3'd0;
    localparam logic [2:0] ERR_COUNT   = 3'd1;
    localparam logic [2:0] ERR_OPCODE  = 3'd2;
    localparam logic [2:0] ERR_CSUM    = 3'd3;
    localparam logic [2:0] ERR_TIMEOUT = 3'd4;

    // High byte of an instruction pair: upper nibble reserved, opcode must be a defined one.
    function automatic logic opcode_byte_ok(input logic [7:0] b);
        return (b[7:4] == 4'd0) && (b[3:0] <= OP_SUB);
    endfunction

endpackage

// File: rtl/stack_program_loader_timeout.sv
// Inter-byte timeout for the program loader: counts idle cycles while a frame is in flight.
module loader_timeout #(
    parameter int LIMIT = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic active,
    input  logic clear,
    output logic hit
);

    localparam int CW = $clog2(LIMIT);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clear || !active) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Fires on the cycle whose edge would bring the count to LIMIT.
    assign hit = active && !clear && (cnt == CW'(LIMIT - 1));

endmodule

// File: rtl/stack_program_loader.sv
// Framed byte-stream loader for the stack machine instruction memory; holds the core until a frame checks out.
// Optional inter-byte timeout is compiled in with LOADER_TIMEOUT_EN.
module stack_program_loader
  import stack_machine_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024
)
(
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic [7:0]          in_data,
  output logic                in_ready,
  input  logic                start,
  output logic                wr_en,
  output logic [ADDR_W-1:0]   wr_addr,
  output logic [INST_W-1:0]   wr_data,
  output logic                core_run,
  output logic                error,
  output logic [2:0]          err_code,
  output loader_state_t       state
);

  localparam logic [7:0] DEPTH_B = 8'(DEPTH);

  // Handshake: a byte transfers on a rising edge where in_valid and in_ready are both high;
  // in_ready depends only on the state register, so it is stable for the whole cycle.

  loader_state_t       state_q, state_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic [ADDR_W-1:0]   index_q, index_d;
  logic [7:0]          csum_q, csum_d;
  logic [3:0]          opcode_q, opcode_d;
  logic [2:0]          err_code_q, err_code_d;
  logic                wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [INST_W-1:0]   wr_data_q, wr_data_d;
  logic [ADDR_W:0]     last_idx;
  logic                accept;
  logic                timeout_hit;

  assign in_ready = (state_q != DONE) && (state_q != ERR);
  assign accept   = in_valid && in_ready;
  assign last_idx = count_q - 1'b1;

`ifdef LOADER_TIMEOUT_EN
  logic frame_active;
  assign frame_active = (state_q == COUNT) || (state_q == HI) ||
                        (state_q == LO) || (state_q == CSUM);

  loader_timeout #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .active (frame_active),
    .clear  (accept || start),
    .hit    (timeout_hit)
  );
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      count_q    <= '0;
      index_q    <= '0;
      csum_q     <= '0;
      opcode_q   <= '0;
      err_code_q <= ERR_NONE;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      index_q    <= index_d;
      csum_q     <= csum_d;
      opcode_q   <= opcode_d;
      err_code_q <= err_code_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    index_d    = index_q;
    csum_d     = csum_q;
    opcode_d   = opcode_q;
    err_code_d = err_code_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;

    // start outranks both the timeout and any byte arriving in the same cycle.
    if (start) begin
      state_d    = IDLE;
      err_code_d = ERR_NONE;
      index_d    = '0;
    end else if (timeout_hit) begin
      state_d    = ERR;
      err_code_d = ERR_TIMEOUT;
    end else if (accept) begin
      case (state_q)
        IDLE: begin
          if (in_data == HEADER) begin
            state_d = COUNT;
          end
        end
        COUNT: begin
          if (in_data == 8'd0 || in_data > DEPTH_B) begin
            state_d    = ERR;
            err_code_d = ERR_COUNT;
          end else begin
            count_d = in_data[ADDR_W:0];
            csum_d  = in_data;
            index_d = '0;
            state_d = HI;
          end
        end
        HI: begin
          if (!opcode_byte_ok(in_data)) begin
            state_d    = ERR;
            err_code_d = ERR_OPCODE;
          end else begin
            opcode_d = in_data[3:0];
            csum_d   = csum_q + in_data;
            state_d  = LO;
          end
        end
        LO: begin
          csum_d    = csum_q + in_data;
          wr_en_d   = 1'b1;
          wr_addr_d = index_q;
          wr_data_d = {opcode_q, in_data};
          // Index holds at the last slot so a full 32-entry frame never wraps it.
          if ({1'b0, index_q} == last_idx) begin
            state_d = CSUM;
          end else begin
            index_d = index_q + 1'b1;
            state_d = HI;
          end
        end
        CSUM: begin
          if (in_data == csum_q) begin
            state_d = DONE;
          end else begin
            state_d    = ERR;
            err_code_d = ERR_CSUM;
          end
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end
  end

  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign core_run = (state_q == DONE);
  assign error    = (state_q == ERR);
  assign err_code = err_code_q;
  assign state    = state_q;

endmodule

// File: tb/tb_stack_program_loader.sv
// Directed bench for stack_program_loader: frame loads, error paths, start/reset aborts, optional timeout.
module tb_stack_program_loader;
  import stack_machine_pkg::*;

  localparam int W = ADDR_W + INST_W;
`ifdef LOADER_TIMEOUT_EN
  localparam int tb_timeout = 16;
`else
  localparam int tb_timeout = 1024;
`endif

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                in_valid = 1'b0;
  logic [7:0]          in_data = 8'h00;
  logic                in_ready;
  logic                start = 1'b0;
  logic                wr_en;
  logic [ADDR_W-1:0]   wr_addr;
  logic [INST_W-1:0]   wr_data;
  logic                core_run;
  logic                error;
  logic [2:0]          err_code;
  loader_state_t       state;

  int total  = 0;
  int passed = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] got_q[$];

  stack_program_loader #(
    .TIMEOUT_CYCLES (tb_timeout)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .start    (start),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .core_run (core_run),
    .error    (error),
    .err_code (err_code),
    .state    (state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // write monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (wr_en === 1'b1) got_q.push_back({wr_addr, wr_data});
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
  endtask

  task automatic send(input logic [7:0] b);
    in_valid = 1'b1;
    in_data  = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_with_start(input logic [7:0] b);
    in_valid = 1'b1;
    in_data  = b;
    start    = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    start    = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic expect_write(input int addr, input logic [INST_W-1:0] data);
    exp_q.push_back({ADDR_W'(addr), data});
  endtask

  // scoreboard: compare captured writes against the expected queue, then drain both
  task automatic check_writes(input string tag);
    int n;
    idle(2);
    check({tag, "_nwrites"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_w%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic check_status(input string tag, input logic run, input logic err,
                              input logic [2:0] code, input logic rdy);
    check({tag, "_core_run"}, 32'(core_run), 32'(run));
    check({tag, "_error"}, 32'(error), 32'(err));
    check({tag, "_err_code"}, 32'(err_code), 32'(code));
    check({tag, "_in_ready"}, 32'(in_ready), 32'(rdy));
  endtask

  initial begin
    logic [7:0] sum;
    logic [7:0] lo;
    logic [3:0] hi;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_status("reset", 1'b0, 1'b0, 3'd0, 1'b1);
    check("reset_wr_en", 32'(wr_en), 32'd0);
    check("reset_wr_addr", 32'(wr_addr), 32'd0);
    check("reset_wr_data", 32'(wr_data), 32'd0);
    check("reset_state", 32'(state), 32'(IDLE));

    // valid two-instruction frame, checksum 02+00+05+06+00 = 0D
    send(8'hA5); send(8'h02); send(8'h00); send(8'h05);
    check("mid_in_ready", 32'(in_ready), 32'd1);
    send(8'h06); send(8'h00);
    check("before_csum_core_run", 32'(core_run), 32'd0);
    send(8'h0D);
    check_status("valid2", 1'b1, 1'b0, 3'd0, 1'b0);
    expect_write(0, 12'h005);
    expect_write(1, 12'h600);
    check_writes("valid2");

    // reset while in DONE drops core_run on the next cycle
    do_reset();
    check_status("rst_done", 1'b0, 1'b0, 3'd0, 1'b1);

    // garbage ahead of the header is discarded
    send(8'h11); send(8'h22);
    check("garbage_in_ready", 32'(in_ready), 32'd1);
    check("garbage_state", 32'(state), 32'(IDLE));
    send(8'hA5); send(8'h01); send(8'h00); send(8'h07); send(8'h08);
    check_status("garbage", 1'b1, 1'b0, 3'd0, 1'b0);
    expect_write(0, 12'h007);
    check_writes("garbage");

    // count of zero
    do_reset();
    send(8'hA5); send(8'h00);
    check_status("count0", 1'b0, 1'b1, 3'd1, 1'b0);
    check_writes("count0");

    // count one above the memory depth
    do_reset();
    send(8'hA5); send(8'h21);
    check_status("count33", 1'b0, 1'b1, 3'd1, 1'b0);
    check_writes("count33");

    // full memory: 32 instructions, addresses 0..31
    do_reset();
    send(8'hA5); send(8'h20);
    sum = 8'h20;
    for (int i = 0; i < DEPTH; i++) begin
      hi = 4'(i % 8);
      lo = 8'(i * 7 + 1);
      send({4'h0, hi});
      send(lo);
      sum = sum + {4'h0, hi} + lo;
      expect_write(i, {hi, lo});
    end
    send(sum);
    check_status("full", 1'b1, 1'b0, 3'd0, 1'b0);
    check_writes("full");

    // bad opcode: defined range exceeded
    do_reset();
    send(8'hA5); send(8'h01); send(8'h09);
    check_status("badop09", 1'b0, 1'b1, 3'd2, 1'b0);
    check_writes("badop09");

    // bad opcode: reserved upper nibble set
    do_reset();
    send(8'hA5); send(8'h01); send(8'h10);
    check_status("badop10", 1'b0, 1'b1, 3'd2, 1'b0);
    check_writes("badop10");

    // checksum mismatch: correct value would be 06, write still committed
    do_reset();
    send(8'hA5); send(8'h01); send(8'h00); send(8'h05); send(8'h00);
    check_status("badcsum", 1'b0, 1'b1, 3'd3, 1'b0);
    expect_write(0, 12'h005);
    check_writes("badcsum");

    // start clears a sticky error
    pulse_start();
    check_status("start_from_err", 1'b0, 1'b0, 3'd0, 1'b1);
    check("start_from_err_state", 32'(state), 32'(IDLE));

    // start mid-frame after A5 02 00, then a clean frame
    do_reset();
    send(8'hA5); send(8'h02); send(8'h00);
    pulse_start();
    check("abort_state", 32'(state), 32'(IDLE));
    check_writes("abort");
    send(8'hA5); send(8'h02); send(8'h00); send(8'h05);
    send(8'h06); send(8'h00); send(8'h0D);
    check_status("after_abort", 1'b1, 1'b0, 3'd0, 1'b0);
    expect_write(0, 12'h005);
    expect_write(1, 12'h600);
    check_writes("after_abort");

    // start coinciding with the LO byte: byte dropped, no write
    do_reset();
    send(8'hA5); send(8'h01); send(8'h03);
    send_with_start(8'h44);
    check("lo_start_state", 32'(state), 32'(IDLE));
    check_writes("lo_start");

    // start coinciding with the wr_en cycle: the scheduled write still fires
    do_reset();
    send(8'hA5); send(8'h01); send(8'h03); send(8'h44);
    check("sched_wr_en", 32'(wr_en), 32'd1);
    pulse_start();
    check("sched_state", 32'(state), 32'(IDLE));
    expect_write(0, 12'h344);
    check_writes("sched");

`ifdef LOADER_TIMEOUT_EN
    // a 15-cycle gap is tolerated, a 16-cycle gap times out
    do_reset();
    send(8'hA5); send(8'h02);
    idle(15);
    check("gap15_error", 32'(error), 32'd0);
    send(8'h00);
    check("gap15_state", 32'(state), 32'(LO));
    idle(16);
    check_status("timeout", 1'b0, 1'b1, 3'd4, 1'b0);
    check_writes("timeout");
`endif

    // final report
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
